// File: rtl/sim_cache_core_if.sv
// sim_cache_core_if: CPU-side I/D Avalon-MM slave ports plus the shared memory master port
interface sim_cache_core_if #(parameter int MEM_AW = 20);
  logic [31:0]       i_address;
  logic              i_read;
  logic [31:0]       i_readdata;
  logic              i_waitrequest;
  logic [31:0]       d_address;
  logic              d_read;
  logic              d_write;
  logic [3:0]        d_byteenable;
  logic [31:0]       d_writedata;
  logic [31:0]       d_readdata;
  logic              d_waitrequest;
  logic [MEM_AW-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;
  logic              m_waitrequest;
  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_byteenable, d_writedata, m_readdata, m_waitrequest,
    output i_readdata, i_waitrequest, d_readdata, d_waitrequest, m_address, m_read, m_write, m_byteenable, m_writedata
  );
  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_byteenable, d_writedata, m_readdata, m_waitrequest,
    input  i_readdata, i_waitrequest, d_readdata, d_waitrequest, m_address, m_read, m_write, m_byteenable, m_writedata
  );
endinterface

// File: rtl/sim_cache_core.sv
// sim_cache_core: split direct-mapped I/D L1 cache (write-through D, coherent I) sharing one memory master
module sim_cache_core #(
  parameter int IDX_W  = 8,
  parameter int MEM_AW = 20
) (
  input logic clk,
  input logic reset,
  sim_cache_core_if.slave bus
);
  localparam int TAG_W = MEM_AW - IDX_W - 2;
  localparam int LINES = 2 ** IDX_W;
  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, DONE} state_t;
  state_t i_st, d_st;
  logic [31:0] i_data [0:LINES-1];
  logic [31:0] d_data [0:LINES-1];
  logic [TAG_W-1:0] i_tag [0:LINES-1];
  logic [TAG_W-1:0] d_tag [0:LINES-1];
  logic [LINES-1:0] i_valid, d_valid;
  logic [IDX_W-1:0] i_idx, d_idx;
  logic [TAG_W-1:0] i_tg, d_tg;
  logic i_hit, d_hit, i_copy, m_own_d, acc, i_fill, d_fill, d_wacc;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    return {be[3] ? n[31:24] : o[31:24], be[2] ? n[23:16] : o[23:16],
            be[1] ? n[15:8]  : o[15:8],  be[0] ? n[7:0]   : o[7:0]};
  endfunction
  // Lookup decode and memory-acceptance events; i_copy flags an I-line shadowing the D-side word
  always_comb begin
    i_idx  = bus.i_address[IDX_W+1:2];
    i_tg   = bus.i_address[MEM_AW-1:IDX_W+2];
    d_idx  = bus.d_address[IDX_W+1:2];
    d_tg   = bus.d_address[MEM_AW-1:IDX_W+2];
    i_hit  = i_valid[i_idx] && i_tag[i_idx] == i_tg;
    d_hit  = d_valid[d_idx] && d_tag[d_idx] == d_tg;
    i_copy = i_valid[d_idx] && i_tag[d_idx] == d_tg;
    acc    = (bus.m_read || bus.m_write) && !bus.m_waitrequest;
    i_fill = acc && bus.m_read && !m_own_d;
    d_fill = acc && bus.m_read && m_own_d;
    d_wacc = acc && bus.m_write;
  end
  // Valid bits are the only cache state cleared by reset; a fill sets its line valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i_valid <= '0;
      d_valid <= '0;
    end else begin
      if (i_fill) i_valid[i_idx] <= 1'b1;
      if (d_fill) d_valid[d_idx] <= 1'b1;
    end
  // Tag/data arrays: fills on read misses, byte merges when a memory write is accepted
  always_ff @(posedge clk) begin
    if (i_fill) begin
      i_tag[i_idx]  <= i_tg;
      i_data[i_idx] <= bus.m_readdata;
    end else if (d_wacc && i_copy) i_data[d_idx] <= merge(i_data[d_idx], bus.m_writedata, bus.m_byteenable);
    if (d_fill) begin
      d_tag[d_idx]  <= d_tg;
      d_data[d_idx] <= bus.m_readdata;
    end else if (d_wacc && d_hit) d_data[d_idx] <= merge(d_data[d_idx], bus.m_writedata, bus.m_byteenable);
  end
  // Per-port FSMs plus the memory arbiter; D wins when both ports wait on an idle memory
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i_st <= IDLE;
      d_st <= IDLE;
      bus.i_waitrequest <= 1'b1;
      bus.d_waitrequest <= 1'b1;
      bus.i_readdata <= '0;
      bus.d_readdata <= '0;
      bus.m_read <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_address <= '0;
      bus.m_byteenable <= 4'hF;
      bus.m_writedata <= '0;
      m_own_d <= 1'b0;
    end else begin
      bus.i_waitrequest <= 1'b1;
      bus.d_waitrequest <= 1'b1;
      case (i_st)
        IDLE: if (bus.i_read) i_st <= LOOKUP;
        LOOKUP: if (i_hit) begin
          i_st <= DONE;
          bus.i_waitrequest <= 1'b0;
          bus.i_readdata <= i_data[i_idx];
        end else i_st <= MEM;
        MEM: if (i_fill) begin
          i_st <= DONE;
          bus.i_waitrequest <= 1'b0;
          bus.i_readdata <= bus.m_readdata;
        end
        default: i_st <= IDLE;
      endcase
      case (d_st)
        IDLE: if (bus.d_read || bus.d_write) d_st <= LOOKUP;
        LOOKUP: if (bus.d_read && d_hit) begin
          d_st <= DONE;
          bus.d_waitrequest <= 1'b0;
          bus.d_readdata <= d_data[d_idx];
        end else d_st <= MEM;
        MEM: if (d_fill || d_wacc) begin
          d_st <= DONE;
          bus.d_waitrequest <= 1'b0;
          bus.d_readdata <= d_fill ? bus.m_readdata : bus.d_readdata;
        end
        default: d_st <= IDLE;
      endcase
      if (acc) begin
        bus.m_read <= 1'b0;
        bus.m_write <= 1'b0;
      end else if (!bus.m_read && !bus.m_write) begin
        if (d_st == MEM) begin
          m_own_d <= 1'b1;
          bus.m_read <= bus.d_read;
          bus.m_write <= bus.d_write;
          bus.m_address <= {bus.d_address[MEM_AW-1:2], 2'b00};
          bus.m_byteenable <= bus.d_write ? bus.d_byteenable : 4'hF;
          bus.m_writedata <= bus.d_writedata;
        end else if (i_st == MEM) begin
          m_own_d <= 1'b0;
          bus.m_read <= 1'b1;
          bus.m_address <= {bus.i_address[MEM_AW-1:2], 2'b00};
          bus.m_byteenable <= 4'hF;
        end
      end
    end
endmodule

// File: tb/tb_sim_cache_core.sv
// tb_sim_cache_core: directed scoreboard bench for the split I/D cache with a random-latency memory
module tb_sim_cache_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  sim_cache_core_if #(.MEM_AW(20)) bus ();
  sim_cache_core #(.IDX_W(8), .MEM_AW(20)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [0:262143] = '{default: '0};
  int wcnt = 0;
  int mrd = 0;
  int vec = 0;
  int miss = 0;
  logic [31:0] i_q [$];
  logic [31:0] d_q [$];
  logic [19:0] rd_log [$];
  assign bus.m_waitrequest = !((bus.m_read || bus.m_write) && wcnt == 0);
  assign bus.m_readdata = mem[bus.m_address[19:2]];
  // memory model: 0-3 random stall cycles per transaction, byte-lane writes, log of accepted reads
  always @(posedge clk)
    if (bus.m_read || bus.m_write) begin
      if (wcnt == 0) begin
        wcnt <= int'($urandom_range(0, 3));
        if (bus.m_read) begin
          mrd <= mrd + 1;
          rd_log.push_back(bus.m_address);
        end
        for (int b = 0; b < 4; b++)
          if (bus.m_write && bus.m_byteenable[b]) mem[bus.m_address[19:2]][8*b+:8] <= bus.m_writedata[8*b+:8];
      end else wcnt <= wcnt - 1;
    end
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  task automatic i_rd(input logic [31:0] a, input logic [31:0] e, input string t, output int n);
    @(posedge clk);
    #1;
    i_q.push_back(e);
    bus.i_address = a;
    bus.i_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.i_waitrequest && n < 200);
    chk({t, "_done"}, 32'(bus.i_waitrequest), 32'd0);
    chk(t, bus.i_readdata, i_q.pop_front());
    @(posedge clk);
    #1 bus.i_read = 1'b0;
  endtask
  task automatic d_rd(input logic [31:0] a, input logic [31:0] e, input string t, output int n);
    @(posedge clk);
    #1;
    d_q.push_back(e);
    bus.d_address = a;
    bus.d_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.d_waitrequest && n < 200);
    chk({t, "_done"}, 32'(bus.d_waitrequest), 32'd0);
    chk(t, bus.d_readdata, d_q.pop_front());
    @(posedge clk);
    #1 bus.d_read = 1'b0;
  endtask
  task automatic d_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input string t);
    int n;
    @(posedge clk);
    #1;
    bus.d_address = a;
    bus.d_writedata = wd;
    bus.d_byteenable = be;
    bus.d_write = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.d_waitrequest && n < 200);
    chk(t, 32'(bus.d_waitrequest), 32'd0);
    @(posedge clk);
    #1 bus.d_write = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, n2, m0;
    bus.i_address = '0;
    bus.i_read = 1'b0;
    bus.d_address = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_byteenable = '0;
    bus.d_writedata = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_iwait", 32'(bus.i_waitrequest), 32'd1);
    chk("rst_dwait", 32'(bus.d_waitrequest), 32'd1);
    chk("rst_irdata", bus.i_readdata, 32'd0);
    chk("rst_drdata", bus.d_readdata, 32'd0);
    chk("rst_mrw", {30'd0, bus.m_read, bus.m_write}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m0 = mrd;
    i_rd(32'h4, 32'h0, "cold", n);
    chk("cold_mrd", 32'(mrd - m0), 32'd1);
    m0 = mrd;
    i_rd(32'h4, 32'h0, "hit", n);
    chk("hit_lat", 32'(n), 32'd3);
    chk("hit_mrd", 32'(mrd - m0), 32'd0);
    d_wr(32'h8, 32'hdead0008, 4'b0111, "pw_wr");
    i_rd(32'h8, 32'h00ad0008, "pw_rd", n);
    for (int k = 1; k <= 100; k++)
      fork
        i_rd(32'(4 * k), (k == 1) ? 32'h0 : (32'h00ad0000 | 32'(4 * k)), "seq_rd", n);
        d_wr(32'(4 * k + 4), 32'hdead0000 | 32'(4 * k + 4), 4'b0111, "seq_wr");
      join
    i_rd(32'h10, 32'h00ad0010, "coh_pre", n);
    chk("coh_pre_lat", 32'(n), 32'd3);
    d_wr(32'h10, 32'h12345678, 4'hF, "coh_wr");
    m0 = mrd;
    i_rd(32'h10, 32'h12345678, "coh_rd", n);
    chk("coh_mrd", 32'(mrd - m0), 32'd0);
    d_wr(32'h10, 32'hffffffff, 4'b0000, "be0_wr");
    i_rd(32'h10, 32'h12345678, "be0_rd", n);
    d_wr(32'h400, 32'hcafe0400, 4'hF, "cf_wr");
    m0 = mrd;
    d_rd(32'h0, 32'h0, "cf_a", n);
    d_rd(32'h400, 32'hcafe0400, "cf_b", n);
    d_rd(32'h0, 32'h0, "cf_c", n);
    chk("cf_mrd", 32'(mrd - m0), 32'd3);
    d_rd(32'h100400, 32'hcafe0400, "wrap", n);
    rd_log.delete();
    fork
      i_rd(32'h404, 32'h0, "arb_i", n);
      d_rd(32'h800, 32'h0, "arb_d", n2);
    join
    chk("arb_first", 32'(rd_log.size() > 0 ? rd_log[0] : 20'hfffff), 32'h800);
    chk("arb_second", 32'(rd_log.size() > 1 ? rd_log[1] : 20'hfffff), 32'h404);
    @(posedge clk);
    #1;
    bus.i_address = 32'h1800;
    bus.i_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_read && n < 50);
    chk("mid_mread", 32'(bus.m_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_iwait", 32'(bus.i_waitrequest), 32'd1);
    chk("mid_dwait", 32'(bus.d_waitrequest), 32'd1);
    chk("mid_mread_off", 32'(bus.m_read), 32'd0);
    bus.i_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m0 = mrd;
    i_rd(32'h4, 32'h0, "post_i", n);
    chk("post_i_mrd", 32'(mrd - m0), 32'd1);
    m0 = mrd;
    d_rd(32'h0, 32'h0, "post_d", n);
    chk("post_d_mrd", 32'(mrd - m0), 32'd1);
    m0 = mrd;
    i_rd(32'h10, 32'h12345678, "post_coh", n);
    chk("post_coh_mrd", 32'(mrd - m0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
